// File: rtl/feature_add_pair_feeder.sv
// Pairs two independently arriving 8-lane feature streams into beat-aligned
// x1/x2 pairs for the residual adder, issuing exactly pair_num pairs per job.
module feature_add_pair_feeder #(
  parameter int FEATURE_WIDTH = 16,
  parameter int FIFO_DEPTH    = 16,
  parameter int LEN_WIDTH     = 16
) (
  input  logic                       system_clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [LEN_WIDTH-1:0]       pair_num,
  input  logic [FEATURE_WIDTH*8-1:0] x1_data_in,
  input  logic                       x1_valid_in,
  output logic                       x1_ready_out,
  input  logic [FEATURE_WIDTH*8-1:0] x2_data_in,
  input  logic                       x2_valid_in,
  output logic                       x2_ready_out,
  output logic [FEATURE_WIDTH*8-1:0] feature_x1_out,
  output logic [FEATURE_WIDTH*8-1:0] feature_x2_out,
  output logic                       feature_x_valid_out,
  output logic                       busy,
  output logic                       done
);

  localparam int DW = FEATURE_WIDTH * 8;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] pair_num_q, pair_num_d;
  logic [LEN_WIDTH-1:0] acc1_q, acc1_d, acc2_q, acc2_d;
  logic [LEN_WIDTH-1:0] issued_q, issued_d;
  logic [AW-1:0]        wr1_q, wr1_d, rd1_q, rd1_d;
  logic [AW-1:0]        wr2_q, wr2_d, rd2_q, rd2_d;
  logic [CW-1:0]        cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic [DW-1:0]        x1_out_q, x1_out_d, x2_out_q, x2_out_d;
  logic                 valid_q, valid_d;
  logic [DW-1:0]        fifo1_mem [FIFO_DEPTH];
  logic [DW-1:0]        fifo2_mem [FIFO_DEPTH];
  logic                 push1, push2, pop;

  always_ff @(posedge system_clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (pair_num == '0) ? DONE : RUN;
      RUN:     if (issued_q == pair_num_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready never looks at valid and offers no bypass: a full FIFO stays closed
  // even in a cycle where it is popped.
  always_comb begin
    busy         = (state_q != IDLE);
    done         = (state_q == DONE);
    x1_ready_out = (state_q == RUN) && (cnt1_q < FULL_CNT) && (acc1_q < pair_num_q);
    x2_ready_out = (state_q == RUN) && (cnt2_q < FULL_CNT) && (acc2_q < pair_num_q);
    pop          = (state_q == RUN) && (cnt1_q != '0) && (cnt2_q != '0);
    push1        = x1_valid_in && x1_ready_out;
    push2        = x2_valid_in && x2_ready_out;
  end

  always_comb begin
    pair_num_d = pair_num_q;
    acc1_d     = acc1_q;
    acc2_d     = acc2_q;
    issued_d   = issued_q;
    wr1_d      = wr1_q;
    wr2_d      = wr2_q;
    rd1_d      = rd1_q;
    rd2_d      = rd2_q;
    cnt1_d     = cnt1_q;
    cnt2_d     = cnt2_q;
    x1_out_d   = x1_out_q;
    x2_out_d   = x2_out_q;
    valid_d    = 1'b0;
    if (state_q == IDLE && start) begin
      pair_num_d = pair_num;
      acc1_d     = '0;
      acc2_d     = '0;
      issued_d   = '0;
    end
    if (push1) begin
      wr1_d  = wr1_q + AW'(1);
      acc1_d = acc1_q + LEN_WIDTH'(1);
    end
    if (push2) begin
      wr2_d  = wr2_q + AW'(1);
      acc2_d = acc2_q + LEN_WIDTH'(1);
    end
    if (pop) begin
      rd1_d    = rd1_q + AW'(1);
      rd2_d    = rd2_q + AW'(1);
      x1_out_d = fifo1_mem[rd1_q];
      x2_out_d = fifo2_mem[rd2_q];
      valid_d  = 1'b1;
      issued_d = issued_q + LEN_WIDTH'(1);
    end
    case ({push1, pop})
      2'b10:   cnt1_d = cnt1_q + CW'(1);
      2'b01:   cnt1_d = cnt1_q - CW'(1);
      default: cnt1_d = cnt1_q;
    endcase
    case ({push2, pop})
      2'b10:   cnt2_d = cnt2_q + CW'(1);
      2'b01:   cnt2_d = cnt2_q - CW'(1);
      default: cnt2_d = cnt2_q;
    endcase
  end

  // Resetting pointers and counts is what discards beats buffered by an
  // aborted job.
  always_ff @(posedge system_clk) begin
    if (!rst_n) begin
      pair_num_q <= '0;
      acc1_q     <= '0;
      acc2_q     <= '0;
      issued_q   <= '0;
      wr1_q      <= '0;
      wr2_q      <= '0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      cnt1_q     <= '0;
      cnt2_q     <= '0;
      x1_out_q   <= '0;
      x2_out_q   <= '0;
      valid_q    <= 1'b0;
    end else begin
      pair_num_q <= pair_num_d;
      acc1_q     <= acc1_d;
      acc2_q     <= acc2_d;
      issued_q   <= issued_d;
      wr1_q      <= wr1_d;
      wr2_q      <= wr2_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      cnt1_q     <= cnt1_d;
      cnt2_q     <= cnt2_d;
      x1_out_q   <= x1_out_d;
      x2_out_q   <= x2_out_d;
      valid_q    <= valid_d;
    end
  end

  always_ff @(posedge system_clk) begin
    if (push1) fifo1_mem[wr1_q] <= x1_data_in;
    if (push2) fifo2_mem[wr2_q] <= x2_data_in;
  end

  assign feature_x1_out      = x1_out_q;
  assign feature_x2_out      = x2_out_q;
  assign feature_x_valid_out = valid_q;

endmodule

// File: tb/tb_feature_add_pair_feeder.sv
// Directed bench for feature_add_pair_feeder: each scenario task drives a job
// and checks pairing, ordering, timing and reset behaviour inline.
module tb_feature_add_pair_feeder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [15:0]  pair_num;
  logic [127:0] x1_data_in, x2_data_in;
  logic         x1_valid_in, x2_valid_in;
  logic         x1_ready_out, x2_ready_out;
  logic [127:0] feature_x1_out, feature_x2_out;
  logic         feature_x_valid_out;
  logic         busy, done;

  int checks = 0;
  int errors = 0;

  int           cyc = 0;
  int           acc1_cnt = 0;
  int           done_cnt = 0;
  int           done_cyc = 0;
  int           overlap_cnt = 0;
  logic [127:0] cap1 [$];
  logic [127:0] cap2 [$];
  int           capc [$];

  feature_add_pair_feeder dut (
    .system_clk          (clk),
    .rst_n               (rst_n),
    .start               (start),
    .pair_num            (pair_num),
    .x1_data_in          (x1_data_in),
    .x1_valid_in         (x1_valid_in),
    .x1_ready_out        (x1_ready_out),
    .x2_data_in          (x2_data_in),
    .x2_valid_in         (x2_valid_in),
    .x2_ready_out        (x2_ready_out),
    .feature_x1_out      (feature_x1_out),
    .feature_x2_out      (feature_x2_out),
    .feature_x_valid_out (feature_x_valid_out),
    .busy                (busy),
    .done                (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Passive monitor on the falling edge, where every signal is settled.
  always @(negedge clk) begin
    if (x1_valid_in && x1_ready_out) acc1_cnt = acc1_cnt + 1;
    if (feature_x_valid_out) begin
      cap1.push_back(feature_x1_out);
      cap2.push_back(feature_x2_out);
      capc.push_back(cyc);
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (done && feature_x_valid_out) overlap_cnt = overlap_cnt + 1;
  end

  function automatic logic [127:0] mk(input logic [15:0] base, input int i);
    logic [127:0] v;
    for (int l = 0; l < 8; l++) v[l*16 +: 16] = base + 16'(i * 8 + l);
    return v;
  endfunction

  task automatic start_job(input logic [15:0] pn);
    @(posedge clk); #1;
    start = 1'b1;
    pair_num = pn;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_x1(input int n, input logic [15:0] base, input int delay);
    int wt;
    repeat (delay) begin @(posedge clk); #1; end
    for (int i = 0; i < n; i++) begin
      x1_valid_in = 1'b1;
      x1_data_in  = mk(base, i);
      wt = 0;
      @(negedge clk);
      while (!x1_ready_out && wt < 300) begin @(negedge clk); wt++; end
      if (!x1_ready_out) begin
        checks++; errors++;
        $display("[TB] FAIL x1_send_timeout: beat %0d never accepted, ready=%0b want 1", i, x1_ready_out);
        x1_valid_in = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    x1_valid_in = 1'b0;
  endtask

  task automatic send_x2(input int n, input logic [15:0] base, input int delay);
    int wt;
    repeat (delay) begin @(posedge clk); #1; end
    for (int i = 0; i < n; i++) begin
      x2_valid_in = 1'b1;
      x2_data_in  = mk(base, i);
      wt = 0;
      @(negedge clk);
      while (!x2_ready_out && wt < 300) begin @(negedge clk); wt++; end
      if (!x2_ready_out) begin
        checks++; errors++;
        $display("[TB] FAIL x2_send_timeout: beat %0d never accepted, ready=%0b want 1", i, x2_ready_out);
        x2_valid_in = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    x2_valid_in = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string name);
    int wt;
    wt = 0;
    while (done_cnt == d0 && wt < 500) begin @(posedge clk); #1; wt++; end
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("[TB] FAIL %s_done_timeout: done count %0d want %0d", name, done_cnt, d0 + 1);
    end
  endtask

  task automatic check_pairs(input int p0, input int n, input logic [15:0] b1,
                             input logic [15:0] b2, input string name);
    checks++;
    if (cap1.size() - p0 != n) begin
      errors++;
      $display("[TB] FAIL %s_pair_count: got %0d want %0d", name, cap1.size() - p0, n);
    end else begin
      for (int i = 0; i < n; i++) begin
        checks++;
        if (cap1[p0+i] !== mk(b1, i) || cap2[p0+i] !== mk(b2, i)) begin
          errors++;
          $display("[TB] FAIL %s_pair%0d: got x1=%h x2=%h want x1=%h x2=%h",
                   name, i, cap1[p0+i], cap2[p0+i], mk(b1, i), mk(b2, i));
        end
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    x1_valid_in = 1'b1;
    x2_valid_in = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if ({busy, done, feature_x_valid_out, x1_ready_out, x2_ready_out} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got busy/done/valid/rdy1/rdy2=%b want 00000",
               {busy, done, feature_x_valid_out, x1_ready_out, x2_ready_out});
    end
    checks++;
    if (feature_x1_out !== '0 || feature_x2_out !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data: got x1=%h x2=%h want 0", feature_x1_out, feature_x2_out);
    end
    x1_valid_in = 1'b0;
    x2_valid_in = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int p0, d0, c1;
    p0 = cap1.size();
    d0 = done_cnt;
    start_job(16'd4);
    c1 = cyc;
    fork
      send_x1(4, 16'h1000, 0);
      send_x2(4, 16'h2000, 0);
    join
    checks++;
    if (x1_ready_out !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_ready_saturate: got ready=%b busy=%b want 0 1", x1_ready_out, busy);
    end
    wait_done(d0, "b2b");
    check_pairs(p0, 4, 16'h1000, 16'h2000, "b2b");
    if (cap1.size() - p0 == 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (capc[p0+i] != c1 + 2 + i) begin
          errors++;
          $display("[TB] FAIL b2b_timing%0d: got cycle %0d want %0d", i, capc[p0+i], c1 + 2 + i);
        end
      end
    end
    checks++;
    if (done_cyc != c1 + 6) begin
      errors++;
      $display("[TB] FAIL b2b_done_cycle: got %0d want %0d", done_cyc, c1 + 6);
    end
    checks++;
    if (overlap_cnt != 0) begin
      errors++;
      $display("[TB] FAIL b2b_overlap: got %0d want 0", overlap_cnt);
    end
    checks++;
    if (feature_x1_out !== mk(16'h1000, 3) || feature_x2_out !== mk(16'h2000, 3)) begin
      errors++;
      $display("[TB] FAIL b2b_hold: got x1=%h want %h", feature_x1_out, mk(16'h1000, 3));
    end
  endtask

  task automatic test_x2_late;
    int p0, d0, c1;
    p0 = cap1.size();
    d0 = done_cnt;
    start_job(16'd3);
    c1 = cyc;
    fork
      send_x1(3, 16'h3000, 0);
      send_x2(3, 16'h4000, 5);
    join
    wait_done(d0, "late");
    check_pairs(p0, 3, 16'h3000, 16'h4000, "late");
    checks++;
    if (cap1.size() - p0 < 1 || capc[p0] != c1 + 7) begin
      errors++;
      $display("[TB] FAIL late_first_valid: got cycle %0d want %0d",
               (cap1.size() > p0) ? capc[p0] : -1, c1 + 7);
    end
    checks++;
    if (done_cyc != c1 + 10) begin
      errors++;
      $display("[TB] FAIL late_done_cycle: got %0d want %0d", done_cyc, c1 + 10);
    end
  endtask

  task automatic test_fifo_full;
    int p0, d0, a0;
    p0 = cap1.size();
    d0 = done_cnt;
    a0 = acc1_cnt;
    start_job(16'd40);
    fork
      send_x1(40, 16'h5000, 0);
      begin
        repeat (30) begin @(posedge clk); #1; end
        checks++;
        if (acc1_cnt - a0 != 16 || x1_ready_out !== 1'b0) begin
          errors++;
          $display("[TB] FAIL full_stall: got accepts=%0d ready=%b want 16 0",
                   acc1_cnt - a0, x1_ready_out);
        end
        send_x2(40, 16'h6000, 0);
      end
    join
    wait_done(d0, "full");
    check_pairs(p0, 40, 16'h5000, 16'h6000, "full");
  endtask

  task automatic test_zero;
    int p0, d0;
    p0 = cap1.size();
    d0 = done_cnt;
    x1_valid_in = 1'b1;
    x2_valid_in = 1'b1;
    start_job(16'd0);
    checks++;
    if ({done, busy, x1_ready_out, x2_ready_out} !== 4'b1100) begin
      errors++;
      $display("[TB] FAIL zero_done: got done/busy/rdy1/rdy2=%b want 1100",
               {done, busy, x1_ready_out, x2_ready_out});
    end
    @(posedge clk); #1;
    checks++;
    if ({done, busy, x1_ready_out, x2_ready_out} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL zero_idle: got done/busy/rdy1/rdy2=%b want 0000",
               {done, busy, x1_ready_out, x2_ready_out});
    end
    x1_valid_in = 1'b0;
    x2_valid_in = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (cap1.size() != p0 || done_cnt != d0 + 1) begin
      errors++;
      $display("[TB] FAIL zero_quiet: got pairs=%0d dones=%0d want 0 1", cap1.size() - p0, done_cnt - d0);
    end
  endtask

  task automatic test_start_busy;
    int p0, d0;
    p0 = cap1.size();
    d0 = done_cnt;
    start_job(16'd2);
    start = 1'b1;
    pair_num = 16'd7;
    @(posedge clk); #1;
    start = 1'b0;
    fork
      send_x1(2, 16'h7000, 0);
      send_x2(2, 16'h7800, 0);
    join
    wait_done(d0, "busy_start");
    check_pairs(p0, 2, 16'h7000, 16'h7800, "busy_start");
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (busy !== 1'b0 || done_cnt != d0 + 1 || cap1.size() != p0 + 2) begin
      errors++;
      $display("[TB] FAIL busy_start_idle: got busy=%b dones=%0d pairs=%0d want 0 1 2",
               busy, done_cnt - d0, cap1.size() - p0);
    end
  endtask

  task automatic test_reset_mid;
    int p0, d0, wt;
    p0 = cap1.size();
    d0 = done_cnt;
    start_job(16'd8);
    fork
      send_x1(4, 16'h8000, 0);
      send_x2(2, 16'h9000, 0);
    join
    wt = 0;
    while (cap1.size() - p0 < 2 && wt < 50) begin @(posedge clk); #1; wt++; end
    check_pairs(p0, 2, 16'h8000, 16'h9000, "mid");
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, feature_x_valid_out, x1_ready_out, x2_ready_out} !== 5'b0 ||
        feature_x1_out !== '0 || feature_x2_out !== '0) begin
      errors++;
      $display("[TB] FAIL mid_reset_outputs: got ctrl=%b x1=%h x2=%h want all 0",
               {busy, done, feature_x_valid_out, x1_ready_out, x2_ready_out},
               feature_x1_out, feature_x2_out);
    end
    rst_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("[TB] FAIL mid_no_done: got dones=%0d want 0", done_cnt - d0);
    end
    p0 = cap1.size();
    start_job(16'd2);
    fork
      send_x1(2, 16'hA000, 0);
      send_x2(2, 16'hB000, 0);
    join
    wait_done(d0, "mid_rerun");
    check_pairs(p0, 2, 16'hA000, 16'hB000, "mid_rerun");
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    pair_num    = '0;
    x1_data_in  = '0;
    x2_data_in  = '0;
    x1_valid_in = 1'b0;
    x2_valid_in = 1'b0;
    test_reset();
    test_back_to_back();
    test_x2_late();
    test_fifo_full();
    test_zero();
    test_start_busy();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
